// File: rtl/csr_excp_unit.sv
// LA32 privileged CSR file on the responder side of the commit/exception controller.
// Optional constant-rate timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built only when CSR_TIMER_EN is defined.
module csr_excp_unit #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_exception_i,
  input  logic [31:0] exception_pc_i,
  input  logic [31:0] exception_addr_i,
  input  logic [5:0]  ecode_i,
  input  logic [8:0]  esubcode_i,
  input  logic        is_ertn_i,
  input  logic        csr_write_en_i,
  input  logic [13:0] csr_write_addr_i,
  input  logic [31:0] csr_write_data_i,
  input  logic        is_llw_scw_i,
  input  logic [13:0] csr_read_addr_i,
  output logic [31:0] csr_read_data_o,
  input  logic [7:0]  hw_int_i,
  input  logic        ipi_i,
  output logic [31:0] eentry_o,
  output logic [31:0] era_o,
  output logic [31:0] crmd_o,
  output logic        is_interrupt_o
);
  localparam logic [13:0] A_CRMD  = 14'h0,  A_PRMD  = 14'h1,  A_ECFG  = 14'h4;
  localparam logic [13:0] A_ESTAT = 14'h5,  A_ERA   = 14'h6,  A_BADV  = 14'h7;
  localparam logic [13:0] A_EENTRY = 14'hC, A_SAVE0 = 14'h30, A_SAVE1 = 14'h31;
  localparam logic [13:0] A_SAVE2 = 14'h32, A_SAVE3 = 14'h33, A_TID   = 14'h40;
  localparam logic [13:0] A_TCFG  = 14'h41, A_TVAL  = 14'h42, A_TICLR = 14'h44;
  localparam logic [13:0] A_LLBCTL = 14'h60;

  // crmd: {PG, DA, IE, PLV[1:0]}; prmd: {PIE, PPLV[1:0]}; lie keeps bit 10 at zero
  logic [4:0]  crmd_q, crmd_d;
  logic [2:0]  prmd_q, prmd_d;
  logic [12:0] lie_q, lie_d;
  logic [1:0]  is_sw_q, is_sw_d;
  logic [7:0]  is_hw_q, is_hw_d;
  logic        is_ipi_q, is_ipi_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] era_q, era_d, badv_q, badv_d;
  logic [25:0] eentry_q, eentry_d;
  logic [31:0] save0_q, save0_d, save1_q, save1_d, save2_q, save2_d, save3_q, save3_d;
  logic [31:0] tid_q, tid_d;
  logic        rollb_q, rollb_d, klo_q, klo_d;
  logic        is_ti;
  logic        wr;
  logic [12:0] is_vec;

`ifdef CSR_TIMER_EN
  logic [31:0] tcfg_q, tcfg_d, tval_q, tval_d;
  logic        timer_on_q, timer_on_d, is_ti_q, is_ti_d;
  assign is_ti = is_ti_q;
`else
  assign is_ti = 1'b0;
`endif

  assign wr     = csr_write_en_i & ~is_exception_i & ~is_ertn_i;
  assign is_vec = {is_ipi_q, is_ti, 1'b0, is_hw_q, is_sw_q};

  always_comb begin
    crmd_d = crmd_q;   prmd_d = prmd_q;   lie_d = lie_q;     is_sw_d = is_sw_q;
    is_hw_d = hw_int_i; is_ipi_d = ipi_i;  ecode_d = ecode_q; esub_d = esub_q;
    era_d = era_q;     badv_d = badv_q;   eentry_d = eentry_q;
    save0_d = save0_q; save1_d = save1_q; save2_d = save2_q; save3_d = save3_q;
    tid_d = tid_q;     rollb_d = rollb_q; klo_d = klo_q;
    if (is_exception_i) begin
      prmd_d       = crmd_q[2:0];
      crmd_d[2:0]  = 3'b000;
      era_d        = exception_pc_i;
      ecode_d      = ecode_i;
      esub_d       = esubcode_i;
      if (ecode_i == 6'h8 && esubcode_i == 9'd0)
        badv_d = exception_pc_i;
      else if ((ecode_i == 6'h8 && esubcode_i == 9'd1) || ecode_i == 6'h9 ||
               (ecode_i >= 6'h1 && ecode_i <= 6'h7) || ecode_i == 6'h3f)
        badv_d = exception_addr_i;
      if (ecode_i == 6'h3f) crmd_d[4:3] = 2'b01;
    end else if (is_ertn_i) begin
      crmd_d[2:0] = prmd_q;
      if (!klo_q) rollb_d = 1'b0;
      klo_d = 1'b0;
      // leaving the TLB-refill handler returns to mapped translation
      if (ecode_q == 6'h3f) crmd_d[4:3] = 2'b10;
    end else if (csr_write_en_i) begin
      case (csr_write_addr_i)
        A_CRMD:   crmd_d = csr_write_data_i[4:0];
        A_PRMD:   prmd_d = csr_write_data_i[2:0];
        A_ECFG:   lie_d  = {csr_write_data_i[12:11], 1'b0, csr_write_data_i[9:0]};
        A_ESTAT: begin
          is_sw_d = csr_write_data_i[1:0];
          ecode_d = csr_write_data_i[21:16];
          esub_d  = csr_write_data_i[30:22];
        end
        A_ERA:    era_d    = csr_write_data_i;
        A_BADV:   badv_d   = csr_write_data_i;
        A_EENTRY: eentry_d = csr_write_data_i[31:6];
        A_SAVE0:  save0_d  = csr_write_data_i;
        A_SAVE1:  save1_d  = csr_write_data_i;
        A_SAVE2:  save2_d  = csr_write_data_i;
        A_SAVE3:  save3_d  = csr_write_data_i;
        A_TID:    tid_d    = csr_write_data_i;
        A_LLBCTL: begin
          if (csr_write_data_i[1]) rollb_d = 1'b0;
          klo_d = csr_write_data_i[2];
        end
        default: ;
      endcase
    end
    if (is_llw_scw_i && !is_exception_i) rollb_d = 1'b1;
  end

`ifdef CSR_TIMER_EN
  always_comb begin
    tcfg_d = tcfg_q; tval_d = tval_q; timer_on_d = timer_on_q; is_ti_d = is_ti_q;
    if (wr && csr_write_addr_i == A_TCFG) begin
      tcfg_d     = csr_write_data_i;
      tval_d     = {csr_write_data_i[31:2], 2'b00};
      timer_on_d = csr_write_data_i[0];
    end else if (timer_on_q) begin
      if (tval_q != 32'd0) begin
        tval_d = tval_q - 32'd1;
        if (tval_q == 32'd1) begin
          is_ti_d = 1'b1;
          if (!tcfg_q[1]) timer_on_d = 1'b0;
        end
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end
    end
    if (wr && csr_write_addr_i == A_TICLR && csr_write_data_i[0]) is_ti_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcfg_q <= '0; tval_q <= '0; timer_on_q <= 1'b0; is_ti_q <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d; tval_q <= tval_d; timer_on_q <= timer_on_d; is_ti_q <= is_ti_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crmd_q <= 5'b01000; prmd_q <= '0; lie_q <= '0; is_sw_q <= '0;
      is_hw_q <= '0; is_ipi_q <= 1'b0; ecode_q <= '0; esub_q <= '0;
      era_q <= '0; badv_q <= '0; eentry_q <= '0;
      save0_q <= '0; save1_q <= '0; save2_q <= '0; save3_q <= '0;
      tid_q <= TID_RESET; rollb_q <= 1'b0; klo_q <= 1'b0;
    end else begin
      crmd_q <= crmd_d; prmd_q <= prmd_d; lie_q <= lie_d; is_sw_q <= is_sw_d;
      is_hw_q <= is_hw_d; is_ipi_q <= is_ipi_d; ecode_q <= ecode_d; esub_q <= esub_d;
      era_q <= era_d; badv_q <= badv_d; eentry_q <= eentry_d;
      save0_q <= save0_d; save1_q <= save1_d; save2_q <= save2_d; save3_q <= save3_d;
      tid_q <= tid_d; rollb_q <= rollb_d; klo_q <= klo_d;
    end
  end

  always_comb begin
    csr_read_data_o = 32'h0;
    case (csr_read_addr_i)
      A_CRMD:   csr_read_data_o = {27'h0, crmd_q};
      A_PRMD:   csr_read_data_o = {29'h0, prmd_q};
      A_ECFG:   csr_read_data_o = {19'h0, lie_q};
      A_ESTAT:  csr_read_data_o = {1'b0, esub_q, ecode_q, 3'b000, is_vec};
      A_ERA:    csr_read_data_o = era_q;
      A_BADV:   csr_read_data_o = badv_q;
      A_EENTRY: csr_read_data_o = {eentry_q, 6'h0};
      A_SAVE0:  csr_read_data_o = save0_q;
      A_SAVE1:  csr_read_data_o = save1_q;
      A_SAVE2:  csr_read_data_o = save2_q;
      A_SAVE3:  csr_read_data_o = save3_q;
      A_TID:    csr_read_data_o = tid_q;
`ifdef CSR_TIMER_EN
      A_TCFG:   csr_read_data_o = tcfg_q;
      A_TVAL:   csr_read_data_o = tval_q;
`endif
      A_LLBCTL: csr_read_data_o = {29'h0, klo_q, 1'b0, rollb_q};
      default:  csr_read_data_o = 32'h0;
    endcase
  end

  assign eentry_o       = {eentry_q, 6'h0};
  assign era_o          = era_q;
  assign crmd_o         = {27'h0, crmd_q};
  assign is_interrupt_o = crmd_q[2] & |(is_vec & lie_q);
endmodule

// File: tb/tb_csr_excp_unit.sv
// Directed bench for csr_excp_unit: event priority, exception/ertn side effects,
// interrupt pending, LLBCTL and (when CSR_TIMER_EN is defined) the timer.
module tb_csr_excp_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        is_exception_i, is_ertn_i, csr_write_en_i, is_llw_scw_i, ipi_i;
  logic [31:0] exception_pc_i, exception_addr_i, csr_write_data_i;
  logic [5:0]  ecode_i;
  logic [8:0]  esubcode_i;
  logic [13:0] csr_write_addr_i, csr_read_addr_i;
  logic [7:0]  hw_int_i;
  logic [31:0] csr_read_data_o, eentry_o, era_o, crmd_o;
  logic        is_interrupt_o;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  csr_excp_unit #(.TID_RESET(32'h1234_5678)) dut (
    .clk(clk), .rst(rst),
    .is_exception_i(is_exception_i), .exception_pc_i(exception_pc_i),
    .exception_addr_i(exception_addr_i), .ecode_i(ecode_i), .esubcode_i(esubcode_i),
    .is_ertn_i(is_ertn_i), .csr_write_en_i(csr_write_en_i),
    .csr_write_addr_i(csr_write_addr_i), .csr_write_data_i(csr_write_data_i),
    .is_llw_scw_i(is_llw_scw_i), .csr_read_addr_i(csr_read_addr_i),
    .csr_read_data_o(csr_read_data_o), .hw_int_i(hw_int_i), .ipi_i(ipi_i),
    .eentry_o(eentry_o), .era_o(era_o), .crmd_o(crmd_o), .is_interrupt_o(is_interrupt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    csr_read_addr_i = addr;
    #1;
    check(tag, csr_read_data_o, exp);
  endtask

  task automatic set_write(input logic [13:0] addr, input logic [31:0] data);
    csr_write_en_i = 1'b1; csr_write_addr_i = addr; csr_write_data_i = data;
  endtask

  task automatic wr_csr(input logic [13:0] addr, input logic [31:0] data);
    set_write(addr, data);
    tick();
    csr_write_en_i = 1'b0;
  endtask

  task automatic set_exc(input logic [5:0] ec, input logic [8:0] es,
                         input logic [31:0] pc, input logic [31:0] addr);
    is_exception_i = 1'b1; ecode_i = ec; esubcode_i = es;
    exception_pc_i = pc; exception_addr_i = addr;
  endtask

  task automatic do_exc(input logic [5:0] ec, input logic [8:0] es,
                        input logic [31:0] pc, input logic [31:0] addr);
    set_exc(ec, es, pc, addr);
    tick();
    is_exception_i = 1'b0;
  endtask

  task automatic do_ertn();
    is_ertn_i = 1'b1;
    tick();
    is_ertn_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    is_exception_i = 0; is_ertn_i = 0; csr_write_en_i = 0; is_llw_scw_i = 0; ipi_i = 0;
    exception_pc_i = 0; exception_addr_i = 0; csr_write_data_i = 0;
    ecode_i = 0; esubcode_i = 0; csr_write_addr_i = 0; csr_read_addr_i = 0; hw_int_i = 0;
    tick(); tick();
    check("rst_crmd", crmd_o, 32'h8);
    check("rst_eentry", eentry_o, 32'h0);
    check("rst_int", {31'h0, is_interrupt_o}, 32'h0);
    rst = 1'b1;
    tick();
    check("crmd_after_rel", crmd_o, 32'h8);
    check("era_after_rel", era_o, 32'h0);
    rd_check("tid_reset", 14'h40, 32'h1234_5678);

    // EENTRY low six bits are not stored
    wr_csr(14'hC, 32'h1C00_803F);
    check("eentry", eentry_o, 32'h1C00_8000);

    wr_csr(14'h0, 32'h7);
    check("crmd_plv3_ie", crmd_o, 32'h7);
    do_exc(6'h9, 9'd0, 32'h1C00_0100, 32'h0000_0003);
    check("exc_crmd", crmd_o, 32'h0);
    rd_check("exc_prmd", 14'h1, 32'h7);
    check("exc_era", era_o, 32'h1C00_0100);
    rd_check("exc_badv", 14'h7, 32'h3);
    rd_check("exc_estat", 14'h5, 32'h0009_0000);
    do_ertn();
    check("ertn_crmd", crmd_o, 32'h7);

    // exception beats a same-cycle CSR write; ecode 0 leaves BADV alone
    set_write(14'h30, 32'hDEAD);
    do_exc(6'h0, 9'd0, 32'h1C00_0200, 32'hFFFF_0000);
    csr_write_en_i = 1'b0;
    rd_check("save0_dropped", 14'h30, 32'h0);
    check("era_exc2", era_o, 32'h1C00_0200);
    rd_check("badv_kept", 14'h7, 32'h3);
    check("exc2_crmd", crmd_o, 32'h0);
    set_write(14'h0, 32'h8);
    do_ertn();
    csr_write_en_i = 1'b0;
    check("ertn_beats_wr", crmd_o, 32'h7);

    wr_csr(14'h4, 32'h4);
    hw_int_i = 8'h01;
    #1;
    check("int_not_yet", {31'h0, is_interrupt_o}, 32'h0);
    tick();
    check("int_pending", {31'h0, is_interrupt_o}, 32'h1);
    rd_check("estat_hw", 14'h5, 32'h4);
    wr_csr(14'h0, 32'h3);
    check("int_masked_ie", {31'h0, is_interrupt_o}, 32'h0);
    hw_int_i = 8'h00;
    wr_csr(14'h1, 32'h7);

    is_llw_scw_i = 1'b1; tick(); is_llw_scw_i = 1'b0;
    rd_check("llbctl_rollb", 14'h60, 32'h1);
    do_ertn();
    rd_check("llbctl_ertn_clr", 14'h60, 32'h0);
    is_llw_scw_i = 1'b1; tick(); is_llw_scw_i = 1'b0;
    wr_csr(14'h60, 32'h4);
    rd_check("llbctl_klo", 14'h60, 32'h5);
    do_ertn();
    rd_check("llbctl_klo_keep", 14'h60, 32'h1);
    wr_csr(14'h60, 32'h2);
    rd_check("llbctl_wcllb", 14'h60, 32'h0);

    wr_csr(14'h0, 32'h1);
    do_exc(6'h3f, 9'd0, 32'h0000_0100, 32'h0000_0044);
    check("refill_crmd", crmd_o, 32'h8);
    rd_check("refill_badv", 14'h7, 32'h44);
    do_ertn();
    check("refill_ertn_crmd", crmd_o, 32'h11);
    do_exc(6'h8, 9'd0, 32'h1C00_0300, 32'h55);
    rd_check("adef_badv", 14'h7, 32'h1C00_0300);
    do_ertn();

    wr_csr(14'h5, 32'h3);
    rd_check("estat_sw", 14'h5, 32'h3);
    wr_csr(14'h4, 32'hFFFF_FFFF);
    rd_check("ecfg_mask", 14'h4, 32'h1BFF);
    wr_csr(14'h2, 32'hFFFF_FFFF);
    rd_check("unknown_addr", 14'h2, 32'h0);
    wr_csr(14'h33, 32'hCAFE_F00D);
    rd_check("save3", 14'h33, 32'hCAFE_F00D);

`ifdef CSR_TIMER_EN
    wr_csr(14'h41, 32'h7);
    for (int i = 4; i >= 0; i--) begin
      rd_check("tval_periodic", 14'h42, i);
      if (i > 0) tick();
    end
    rd_check("estat_ti_set", 14'h5, 32'h803);
    tick();
    rd_check("tval_reload", 14'h42, 32'h4);
    wr_csr(14'h41, 32'h0);
    wr_csr(14'h44, 32'h1);
    rd_check("estat_ticlr", 14'h5, 32'h3);
    wr_csr(14'h41, 32'h5);
    for (int i = 0; i < 5; i++) tick();
    rd_check("tval_oneshot_hold", 14'h42, 32'h0);
    rd_check("estat_oneshot", 14'h5, 32'h803);
    wr_csr(14'h44, 32'h1);
    wr_csr(14'h41, 32'h7);
    tick(); tick();
`else
    wr_csr(14'h41, 32'h7);
    for (int i = 0; i < 6; i++) tick();
    rd_check("tval_absent", 14'h42, 32'h0);
    rd_check("tcfg_absent", 14'h41, 32'h0);
    rd_check("estat_no_ti", 14'h5, 32'h3);
`endif

    // asynchronous reset mid-operation, no clock edge needed
    rst = 1'b0;
    #1;
    check("midrst_crmd", crmd_o, 32'h8);
    check("midrst_era", era_o, 32'h0);
    rd_check("midrst_tval", 14'h42, 32'h0);
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
